fifo_op_sched: RTL
==================

# fifo_op_sched

Operation scheduler for the FIFO demo datapath. It converts debounced push/pop button levels into single-cycle FIFO write/read strobes. It arbitrates simultaneous requests round-robin and rejects operations that would overflow or underflow the FIFO. Operations can be paced by an internal step tick (one operation per tick) or issued immediately. The step tick is a single-cycle enable in the clk100MHz domain, not a derived clock.

## Interface
- TICK_DIV, 400000000: step tick period in clk100MHz cycles (4 s); ≥4; benches override small.
- clk100MHz  in  1  system clock, 100 MHz; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- push_btn  in  1  debounced, already-synchronous push request level.
- pop_btn  in  1  debounced, already-synchronous pop request level.
- step_mode  in  1  1 = issue only on tick; 0 = issue immediately.
- fifo_full  in  1  FIFO full flag.
- fifo_empty  in  1  FIFO empty flag.
- clear_err  in  1  clears sticky error flags.
- fifo_wr_en  out  1  one-cycle write strobe.
- fifo_rd_en  out  1  one-cycle read strobe.
- tick  out  1  one-cycle step pulse, every TICK_DIV cycles.
- busy  out  1  high in any state other than IDLE.
- last_op  out  2  00 none, 01 push done, 10 pop done, 11 rejected.
- err_overflow  out  1  sticky: a push was rejected because the FIFO was full.
- err_underflow  out  1  sticky: a pop was rejected because the FIFO was empty.

## Operation
- Edge detect: registered copies of push_btn/pop_btn. A rising edge sets push_pend/pop_pend on the next clock. An edge while the same pend is already set is ignored, so depth is one per type. Held levels generate nothing further.
- Tick counter: free-running 0..TICK_DIV-1, wraps to 0. tick=1 exactly when count==TICK_DIV-1.
- FSM states:
  - IDLE: if any pend is set, go to WAIT_TICK when step_mode=1, else to ISSUE.
  - WAIT_TICK: go to ISSUE on a tick cycle, or on any cycle where step_mode=0.
  - ISSUE: one cycle; drives the granted strobe.
  - SETTLE: one cycle to let FIFO flags update; then IDLE.
- Grant and check, on the cycle that enters ISSUE:
  - Grant: with only one pend set, grant it. With both set, grant the type not granted last. The priority bit resets to favour push.
  - Push granted with fifo_full=1: no strobe; err_overflow=1; last_op=11.
  - Pop granted with fifo_empty=1: no strobe; err_underflow=1; last_op=11.
  - Otherwise: the strobe asserts during ISSUE; last_op=01 or 10.
  - The granted pend clears on entering ISSUE. The other pend is kept and served in a later pass.
- Error flags: clear_err zeroes both flags. A set event in the same cycle wins over clear_err.
- Reset: every output is 0 (fifo_wr_en, fifo_rd_en, tick, busy, last_op=00, both err flags). Also cleared: state=IDLE, both pends, the button history registers, tick count=0, priority=push. Reset mid-ISSUE drops the strobe on the next edge and issues no further operation.

## Timing
- Registered outputs only; strobes never exceed one cycle.
- Immediate mode: rising edge sampled at cycle N → pend at N+1 → ISSUE (strobe high) at N+2 → SETTLE at N+3 → IDLE at N+4.
- Back-to-back pends: strobes are at least 3 cycles apart (ISSUE, SETTLE, IDLE).
- Step mode: the strobe occurs in the cycle after the first tick that arrives while in WAIT_TICK. At most one operation per tick.
- A tick in the same cycle as IDLE→WAIT_TICK is not consumed; the block waits for the next tick.
- busy is high from the cycle after the pend is detected through SETTLE.

## Test plan
- Reset then immediate push, with fifo_full=0: push_btn rises at cycle 10 → fifo_wr_en=1 at cycle 12 only; last_op=01 at 13; busy low at 14.
- Simultaneous push and pop edges, both flags 0: wr_en at +2, rd_en at +5; a second simultaneous pair then grants pop first, following round-robin.
- Pop with fifo_empty=1: no rd_en; err_underflow=1 and last_op=11. clear_err then clears the flag. clear_err in the same cycle as a new rejection leaves the flag at 1.
- Step mode, TICK_DIV=8: push requested at cycle 3 → wr_en in the cycle after the next tick; a second push during the wait is ignored; exactly one wr_en per tick.
- rst asserted during WAIT_TICK with both pends set: all outputs are 0 next cycle; no strobe on subsequent ticks until new edges arrive.
- Held push_btn for 100 cycles: exactly one wr_en.

Source files
------------

// File: rtl/fifo_op_sched.sv
// fifo_op_sched: turns push/pop button edges into paced, checked single-cycle FIFO strobes
module fifo_op_sched #(
  parameter int TICK_DIV = 400000000
) (
  input  logic       clk100MHz,
  input  logic       rst,
  input  logic       push_btn,
  input  logic       pop_btn,
  input  logic       step_mode,
  input  logic       fifo_full,
  input  logic       fifo_empty,
  input  logic       clear_err,
  output logic       fifo_wr_en,
  output logic       fifo_rd_en,
  output logic       tick,
  output logic       busy,
  output logic [1:0] last_op,
  output logic       err_overflow,
  output logic       err_underflow
);
  localparam int CW = $clog2(TICK_DIV);
  typedef enum logic [1:0] {IDLE, WAIT_TICK, ISSUE, SETTLE} state_t;
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic push_q, pop_q, push_pend, pop_pend, prio_pop;
  logic go, g_push, g_pop, rej_push, rej_pop;
  // next state, grant and rejection decided on the cycle that enters ISSUE
  always_comb begin
    nxt = state;
    case (state)
      IDLE:      if (push_pend | pop_pend) nxt = step_mode ? WAIT_TICK : ISSUE;
      WAIT_TICK: if (tick | ~step_mode) nxt = ISSUE;
      ISSUE:     nxt = SETTLE;
      default:   nxt = IDLE;
    endcase
    go       = (nxt == ISSUE);
    g_push   = go & push_pend & (~pop_pend | ~prio_pop);
    g_pop    = go & pop_pend & ~g_push;
    rej_push = g_push & fifo_full;
    rej_pop  = g_pop & fifo_empty;
  end
  // free-running step counter; tick registered so it is high while cnt is TICK_DIV-1
  always_ff @(posedge clk100MHz) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= (cnt == CW'(TICK_DIV - 1)) ? '0 : cnt + 1'b1;
      tick <= (cnt == CW'(TICK_DIV - 2));
    end
  end
  // edge capture into one-deep pends; a pend that is already set swallows new edges
  always_ff @(posedge clk100MHz) begin
    if (rst) begin
      push_q    <= 1'b0;
      pop_q     <= 1'b0;
      push_pend <= 1'b0;
      pop_pend  <= 1'b0;
    end else begin
      push_q    <= push_btn;
      pop_q     <= pop_btn;
      push_pend <= g_push ? 1'b0 : push_pend | (push_btn & ~push_q);
      pop_pend  <= g_pop ? 1'b0 : pop_pend | (pop_btn & ~pop_q);
    end
  end
  // state register
  always_ff @(posedge clk100MHz) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end
  // registered strobes, status, sticky errors and round-robin priority (contested grants only)
  always_ff @(posedge clk100MHz) begin
    if (rst) begin
      fifo_wr_en    <= 1'b0;
      fifo_rd_en    <= 1'b0;
      busy          <= 1'b0;
      last_op       <= 2'b00;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
      prio_pop      <= 1'b0;
    end else begin
      fifo_wr_en    <= g_push & ~fifo_full;
      fifo_rd_en    <= g_pop & ~fifo_empty;
      busy          <= (nxt != IDLE);
      last_op       <= go ? ((rej_push | rej_pop) ? 2'b11 : g_push ? 2'b01 : 2'b10) : last_op;
      err_overflow  <= rej_push | (err_overflow & ~clear_err);
      err_underflow <= rej_pop | (err_underflow & ~clear_err);
      prio_pop      <= (push_pend & pop_pend & go) ? g_push : prio_pop;
    end
  end
endmodule
